sha256_round_ctrl: RTL
======================

Name: sha256_round_ctrl

Overview:
- Sequential SHA-256 compression engine; sequences the Σ0/Σ1/σ0/σ1/Ch/Maj round functions over 64 rounds, one round per clock.
- Accepts one 512-bit message block as 16 serial 32-bit words and chains the hash state across blocks.
- Sits beside the core as a memory-mapped or coprocessor peer; software supplies blocks that are already padded.

Parameters:
- NUM_ROUNDS, 64, rounds per block. Only 64 is legal for SHA-256; smaller values are for debug benches only.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- init_i  in  1  load IV into H before the next block; honoured only in IDLE with word count 0
- abort_i  in  1  abandon the current block and return to IDLE; H is unchanged
- word_valid_i  in  1  message word valid
- word_ready_o  out  1  engine accepts a word; high only in IDLE
- word_i  in  32  message word, big-endian, W0 first
- busy_o  out  1  high in ROUND or FINAL
- digest_valid_o  out  1  digest_o holds the result of the last completed block
- digest_o  out  256  {H0..H7}; H0 at [255:224]

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state=IDLE, word count=0.
  - H=IV {6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19}.
  - Outputs: digest_o=IV, digest_valid_o=0, busy_o=0, word_ready_o=1 once reset is released.
- IDLE state:
  - A word transfers when word_valid_i & word_ready_o; it is written to W buffer slot [count], then count increments.
  - Any transfer clears digest_valid_o.
  - init_i=1 at count 0 sets H=IV at that edge. If it coincides with word 0, both take effect.
- Block start:
  - On transfer of word 15 (edge T), the working regs a..h load from H, t=0, state becomes ROUND.
- ROUND state (edges T+1..T+64):
  - Wt = buf[t] for t<16.
  - For t>=16: Wt = σ1(buf[(t-2)%16]) + buf[(t-7)%16] + σ0(buf[(t-15)%16]) + buf[t%16], written back to buf[t%16].
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + Wt; T2 = Σ0(a) + Maj(a,b,c).
  - Register shift: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All additions are modulo 2^32. K[0..63] is the standard 64-entry constant ROM.
  - t increments; after the t=NUM_ROUNDS-1 update, state becomes FINAL.
- Round functions:
  - Σ0 = rotr2 ^ rotr13 ^ rotr22
  - Σ1 = rotr6 ^ rotr11 ^ rotr25
  - σ0 = rotr7 ^ rotr18 ^ shr3
  - σ1 = rotr17 ^ rotr19 ^ shr10
  - Ch = g ^ (e & (f ^ g)); Maj = (a&b) | (c&(a|b))
- FINAL state (edge T+65):
  - Hi += working reg i (mod 2^32), digest_valid_o=1, state=IDLE, count=0.
  - Digest latency: 65 cycles from the word-15 edge to digest_valid_o high.
- Handshake:
  - word_ready_o=0 in ROUND and FINAL; word_valid_i is ignored there.
  - digest_o changes only at a FINAL edge, reset, or IDLE init.
- abort_i:
  - Has priority over every other event.
  - Next edge: state=IDLE, count=0, H retained, digest_valid_o=0.
  - Partially loaded buffer words are discarded.
- Reset mid-block: immediate return to the reset values listed above.

Test Plan:
- "abc" block: init_i=1 with W0=61626380, W1..W14=0, W15=00000018 -> exactly 65 cycles after W15, digest_valid_o=1 and digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: init_i=1, W0=80000000, rest 0 -> digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block chaining, "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": init only on block 1, block 2 with init_i=0 -> digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: random word_valid_i gaps while loading, plus word_valid_i held high during ROUND -> word_ready_o=0 for 65 cycles, no extra words consumed, "abc" digest unchanged.
- abort_i after 7 words, then a full "abc" block with init_i=1 -> correct "abc" digest. abort_i at round 30 -> IDLE next cycle, digest_valid_o=0, H unchanged.
- rst_i asserted at round 40 -> outputs at reset values immediately (asynchronous), digest_o=IV, word_ready_o=1 after release.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl
//
// Sequential SHA-256 compression engine. One padded 512-bit block is loaded
// as 16 big-endian 32-bit words (W0 first). The engine then runs one round
// per clock over NUM_ROUNDS rounds and folds the working registers back into
// the chained hash state H in a final cycle.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous reset, active-high
//   init_i         load IV into H (only in IDLE with no words buffered)
//   abort_i        drop the current block, return to IDLE, keep H
//   word_valid_i   message word valid
//   word_ready_o   engine accepts a word (IDLE only)
//   word_i         message word
//   busy_o         high while rounds or the final fold are in progress
//   digest_valid_o digest_o holds the result of the last completed block
//   digest_o       {H0..H7}, H0 in [255:224]
// ---------------------------------------------------------------------------
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         init_i,
    input  logic         abort_i,
    input  logic         word_valid_i,
    output logic         word_ready_o,
    input  logic [31:0]  word_i,
    output logic         busy_o,
    output logic         digest_valid_o,
    output logic [255:0] digest_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // State
    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] h_q   [8];
    logic [31:0] h_d   [8];
    logic [31:0] wk_q  [8];     // working registers a..h at index 0..7
    logic [31:0] wk_d  [8];
    logic [31:0] buf_q [16];    // rolling 16-entry message schedule window
    logic [31:0] buf_d [16];
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        dv_q, dv_d;

    // Round datapath
    logic [3:0]  idx_m2, idx_m7, idx_m15, idx_0;
    logic [31:0] w_sched, wt, ch, maj, t1, t2;

    // The schedule window is indexed modulo 16, so t-2, t-7 and t-15 become
    // 4-bit offsets of +14, +9 and +1 from the current slot.
    assign idx_0   = t_q[3:0];
    assign idx_m2  = t_q[3:0] + 4'd14;
    assign idx_m7  = t_q[3:0] + 4'd9;
    assign idx_m15 = t_q[3:0] + 4'd1;

    always_comb begin
        w_sched = ssig1(buf_q[idx_m2]) + buf_q[idx_m7]
                + ssig0(buf_q[idx_m15]) + buf_q[idx_0];
        wt  = (t_q[5:4] == 2'b00) ? buf_q[idx_0] : w_sched;
        ch  = wk_q[6] ^ (wk_q[4] & (wk_q[5] ^ wk_q[6]));
        maj = (wk_q[0] & wk_q[1]) | (wk_q[2] & (wk_q[0] | wk_q[1]));
        t1  = wk_q[7] + bsig1(wk_q[4]) + ch + K[t_q] + wt;
        t2  = bsig0(wk_q[0]) + maj;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        t_d     = t_q;
        h_d     = h_q;
        wk_d    = wk_q;
        buf_d   = buf_q;
        dv_d    = dv_q;

        if (abort_i) begin
            state_d = ST_IDLE;
            count_d = 4'd0;
            dv_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (init_i && count_q == 4'd0) begin
                        h_d  = IV;
                        dv_d = 1'b0;
                    end
                    if (word_valid_i) begin
                        buf_d[count_q] = word_i;
                        count_d        = count_q + 4'd1;   // wraps to 0 after W15
                        dv_d           = 1'b0;
                        if (count_q == 4'd15) begin
                            // init cannot coincide with W15, so H is current.
                            wk_d    = h_q;
                            t_d     = 6'd0;
                            state_d = ST_ROUND;
                        end
                    end
                end
                ST_ROUND: begin
                    wk_d[0] = t1 + t2;
                    wk_d[1] = wk_q[0];
                    wk_d[2] = wk_q[1];
                    wk_d[3] = wk_q[2];
                    wk_d[4] = wk_q[3] + t1;
                    wk_d[5] = wk_q[4];
                    wk_d[6] = wk_q[5];
                    wk_d[7] = wk_q[6];
                    if (t_q[5:4] != 2'b00) begin
                        buf_d[idx_0] = w_sched;
                    end
                    t_d = t_q + 6'd1;
                    if (t_q == LAST_ROUND) begin
                        state_d = ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        h_d[i] = h_q[i] + wk_q[i];
                    end
                    dv_d    = 1'b1;
                    count_d = 4'd0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 4'd0;
                end
            endcase
        end

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            count_q <= 4'd0;
            t_q     <= 6'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= IV[i];
                wk_q[i] <= 32'd0;
            end
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            t_q     <= t_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            h_q     <= h_d;
            wk_q    <= wk_d;
            buf_q   <= buf_d;
        end
    end

    assign word_ready_o   = ready_q;
    assign busy_o         = busy_q;
    assign digest_valid_o = dv_q;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digest
            assign digest_o[255 - 32*gi -: 32] = h_q[gi];
        end
    endgenerate

endmodule
